// File: rtl/cla_adder32_pipe.sv
// rtl/cla_adder32_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_adder32_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEC = WIDTH / 16;

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             c0_q, c0_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             s1_v_q, s1_v_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic             s2_en;
    logic             accept;
    logic [WIDTH-1:0] b_eff;

    logic [WIDTH:0]   carry;
    logic [3:0]       pn, gn;
    logic [3:0]       grp_p, grp_g;
    logic [4:0]       grp_c;
    logic             sec_c;
    logic [WIDTH-1:0] sum_w;

    // Handshake: stage 2 frees up whenever its result is taken, which may also free stage 1.
    always_comb begin
        s2_en    = !out_valid_q || out_ready;
        in_ready = !s1_v_q || s2_en;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        b_eff   = sub ? ~b : b;
        p_d     = p_q;
        g_d     = g_q;
        c0_d    = c0_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s1_v_d  = s1_v_q;
        if (in_ready) begin
            s1_v_d = in_valid;
        end
        if (accept) begin
            p_d     = a ^ b_eff;
            g_d     = a & b_eff;
            c0_d    = sub ? 1'b1 : cin;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b_eff[WIDTH-1];
        end
    end

    // Lookahead inside each 16-bit section (4 groups of 4 bits); section carries ripple.
    always_comb begin
        carry = '0;
        pn    = '0;
        gn    = '0;
        grp_p = '0;
        grp_g = '0;
        grp_c = '0;
        sec_c = c0_q;
        for (int s = 0; s < NSEC; s++) begin
            for (int k = 0; k < 4; k++) begin
                pn       = p_q[16*s+4*k +: 4];
                gn       = g_q[16*s+4*k +: 4];
                grp_p[k] = &pn;
                grp_g[k] = gn[3]
                         | (pn[3] & gn[2])
                         | (pn[3] & pn[2] & gn[1])
                         | (pn[3] & pn[2] & pn[1] & gn[0]);
            end
            grp_c[0] = sec_c;
            grp_c[1] = grp_g[0]
                     | (grp_p[0] & sec_c);
            grp_c[2] = grp_g[1]
                     | (grp_p[1] & grp_g[0])
                     | (grp_p[1] & grp_p[0] & sec_c);
            grp_c[3] = grp_g[2]
                     | (grp_p[2] & grp_g[1])
                     | (grp_p[2] & grp_p[1] & grp_g[0])
                     | (grp_p[2] & grp_p[1] & grp_p[0] & sec_c);
            grp_c[4] = grp_g[3]
                     | (grp_p[3] & grp_g[2])
                     | (grp_p[3] & grp_p[2] & grp_g[1])
                     | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                     | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & sec_c);
            for (int k = 0; k < 4; k++) begin
                pn = p_q[16*s+4*k +: 4];
                gn = g_q[16*s+4*k +: 4];
                carry[16*s+4*k +: 4] = {
                    gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
                          | (pn[2] & pn[1] & pn[0] & grp_c[k]),
                    gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & grp_c[k]),
                    gn[0] | (pn[0] & grp_c[k]),
                    grp_c[k]
                };
            end
            sec_c = grp_c[4];
        end
        carry[WIDTH] = sec_c;
    end

    always_comb begin
        sum_w       = p_q ^ carry[WIDTH-1:0];
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (s2_en) begin
            out_valid_d = s1_v_q;
        end
        if (s2_en && s1_v_q) begin
            sum_d  = sum_w;
            cout_d = carry[WIDTH];
            // Same-sign operands giving an opposite-sign result; equals c[W]^c[W-1].
            ovf_d  = (a_msb_q ~^ b_msb_q) & (sum_w[WIDTH-1] ^ a_msb_q);
            zero_d = (sum_w == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            g_q         <= '0;
            c0_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            s1_v_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            g_q         <= g_d;
            c0_q        <= c0_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            s1_v_q      <= s1_v_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_adder32_pipe.sv
// tb/tb_cla_adder32_pipe.sv - randomized and directed self-checking bench for cla_adder32_pipe
module tb_cla_adder32_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b0, cout, ovf, zero;
    logic [31:0] a = '0, b = '0, sum;

    logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b1, cout16, ovf16, zero16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   delivered = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    cla_adder32_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_adder32_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned sum for result/carry, signed integer range for overflow.
    function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                   input logic tc, input logic ts);
        res_t        r;
        logic [32:0] full;
        longint      sa, sb, sr, hi, lo;
        full = ts ? ({1'b0, ta} + {1'b0, ~tb_v} + 33'd1) : ({1'b0, ta} + {1'b0, tb_v} + {32'd0, tc});
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_v));
        sr = ts ? (sa - sb) : (sa + sb + longint'(tc));
        hi = (longint'(1) << 31) - 1;
        lo = -(longint'(1) << 31);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (sr > hi) || (sr < lo);
        r.zero = (full[31:0] == 32'd0);
        return r;
    endfunction

    initial begin : monitor
        res_t r;
        res_t hold_r;
        logic hold_chk;
        hold_chk = 1'b0;
        hold_r   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_chk = 1'b0;
            end else begin
                chk("in_ready", {63'd0, in_ready}, {63'd0, !(exp_q.size() == 2 && !out_ready)});
                if (hold_chk)
                    chk("stall_hold", {28'd0, out_valid, sum, cout, ovf, zero}, {28'd0, 1'b1, hold_r});
                if (out_valid && exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else if (out_valid && out_ready) begin
                    r = exp_q.pop_front();
                    chk("result", {29'd0, sum, cout, ovf, zero}, {29'd0, r});
                    delivered++;
                end
                hold_chk = out_valid && !out_ready;
                hold_r   = {sum, cout, ovf, zero};
                if (in_valid && in_ready)
                    exp_q.push_back(model(a, b, cin, sub));
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input logic ts);
        logic acc;
        int   n;
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accepted", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_in_ready16", {63'd0, in_ready16}, 64'd1);

        chk("model_basic", {29'd0, model(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0)}, {29'd0, 32'h0, 1'b1, 1'b0, 1'b1});
        chk("model_ovf", {29'd0, model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)}, {29'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        chk("model_sub", {29'd0, model(32'd5, 32'd7, 1'b1, 1'b1)}, {29'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        chk("model_chain", {29'd0, model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0)}, {29'd0, 32'h0, 1'b1, 1'b0, 1'b1});
        chk("model_subovf", {29'd0, model(32'h8000_0000, 32'h1, 1'b0, 1'b1)}, {29'd0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with explicit two-cycle latency.
        a = 32'h0000_0001; b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_sum", {32'd0, sum}, 64'd0);
        chk("basic_flags", {61'd0, cout, ovf, zero}, {61'd0, 3'b101});
        @(posedge clk);
        #1;

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back stream: one result per cycle.
        d0 = delivered;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            if (i % 25 == 7) begin a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; end
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_throughput", delivered - d0, 64'd98);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("stream_count", delivered - d0, 64'd100);

        // Backpressure: two accepts then stall five cycles.
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b1, 1'b1);
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_accept", {62'd0, in_ready, out_valid}, 64'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Random valid/ready mix.
        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_sum", {32'd0, sum}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_no_result", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end

        // 16-bit build.
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w16_out_valid", {63'd0, out_valid16}, 64'd1);
        chk("w16_sum", {48'd0, sum16}, 64'd0);
        chk("w16_flags", {61'd0, cout16, ovf16, zero16}, {61'd0, 3'b111});

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
